// File: rtl/snake_step_if.sv
// snake_step_if: handshake/status bundle between the tick/input front end and
// the snake step sequencer.
//   tick       one-cycle step request
//   pause      blocks step acceptance while high
//   dir_in     requested direction (00 up, 01 down, 10 left, 11 right)
//   dir_valid  dir_in is sampled this cycle
//   head_x/y   current head position
//   dir        direction committed for the current/last step
//   busy       step in progress
//   step_done  one-cycle pulse, head_x/head_y are new this cycle
//   wall_hit   sticky wall collision flag
interface snake_step_if;
  logic       tick;
  logic       pause;
  logic [1:0] dir_in;
  logic       dir_valid;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       busy;
  logic       step_done;
  logic       wall_hit;

  modport master (
    output tick, pause, dir_in, dir_valid,
    input  head_x, head_y, dir, busy, step_done, wall_hit
  );

  modport slave (
    input  tick, pause, dir_in, dir_valid,
    output head_x, head_y, dir, busy, step_done, wall_hit
  );
endinterface

// File: rtl/snake_step_sequencer.sv
// snake_step_sequencer: advances the snake head one cell per accepted tick.
// A single 5-bit add/subtract unit is shared between the X and Y axes; each
// step walks IDLE -> LATCH -> CALC -> COMMIT and pulses step_done on return.
// Edges either wrap (WRAP=1) or raise a sticky wall_hit that blocks stepping.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  snake_step_if slave: tick/pause/dir_in/dir_valid in,
//        head_x/head_y/dir/busy/step_done/wall_hit out (all registered)
module snake_step_sequencer #(
  parameter int unsigned GRID_W  = 32,
  parameter int unsigned GRID_H  = 32,
  parameter int unsigned START_X = 16,
  parameter int unsigned START_Y = 16,
  parameter bit          WRAP    = 1'b1
) (
  input logic         clk,
  input logic         rst,
  snake_step_if.slave bus
);

  localparam logic [4:0] XMax   = 5'(GRID_W - 1);
  localparam logic [4:0] YMax   = 5'(GRID_H - 1);
  localparam logic [4:0] StartX = 5'(START_X);
  localparam logic [4:0] StartY = 5'(START_Y);

  typedef enum logic [1:0] {StIdle, StLatch, StCalc, StCommit} state_e;

  state_e     state_q;
  logic [4:0] head_x_q, head_y_q;
  logic [1:0] dir_q, pending_q;
  logic       busy_q, done_q, wall_q;
  logic       axis_y_q;   // 1: step acts on Y
  logic       op_inc_q;   // 1: +1, 0: -1
  logic [4:0] operand_q;
  logic [4:0] sum_q;
  logic       bound_q;    // step would leave the grid

  logic [4:0] alu_b;
  logic       alu_cin;
  logic [4:0] alu_sum;
  logic [4:0] axis_max;
  logic       at_bound;
  logic [4:0] commit_val;
  logic       is_reverse;

  // Shared datapath: A + B for increment, A + ~B + 1 for decrement (B = 1).
  always_comb begin
    alu_b      = op_inc_q ? 5'd1 : ~5'd1;
    alu_cin    = ~op_inc_q;
    alu_sum    = operand_q + alu_b + {4'b0, alu_cin};
    axis_max   = axis_y_q ? YMax : XMax;
    at_bound   = op_inc_q ? (operand_q == axis_max) : (operand_q == 5'd0);
    // On a wrapping edge crossing the head lands on the opposite edge.
    commit_val = !bound_q ? sum_q : (op_inc_q ? 5'd0 : axis_max);
    // Reversal only flips the low bit within the same axis.
    is_reverse = (bus.dir_in[1] == dir_q[1]) && (bus.dir_in[0] != dir_q[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      head_x_q  <= StartX;
      head_y_q  <= StartY;
      dir_q     <= 2'b11;
      pending_q <= 2'b11;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wall_q    <= 1'b0;
      axis_y_q  <= 1'b0;
      op_inc_q  <= 1'b0;
      operand_q <= 5'd0;
      sum_q     <= 5'd0;
      bound_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Checked against the committed direction, so two quick requests
      // cannot chain into an immediate reversal.
      if (bus.dir_valid && !is_reverse) begin
        pending_q <= bus.dir_in;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.tick && !bus.pause && !wall_q) begin
            state_q <= StLatch;
            busy_q  <= 1'b1;
          end
        end
        StLatch: begin
          dir_q     <= pending_q;
          axis_y_q  <= ~pending_q[1];
          op_inc_q  <= pending_q[0];
          operand_q <= pending_q[1] ? head_x_q : head_y_q;
          state_q   <= StCalc;
        end
        StCalc: begin
          sum_q   <= alu_sum;
          bound_q <= at_bound;
          state_q <= StCommit;
        end
        StCommit: begin
          if (!bound_q || WRAP) begin
            if (axis_y_q) head_y_q <= commit_val;
            else          head_x_q <= commit_val;
          end else begin
            wall_q <= 1'b1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.head_x    = head_x_q;
  assign bus.head_y    = head_y_q;
  assign bus.dir       = dir_q;
  assign bus.busy      = busy_q;
  assign bus.step_done = done_q;
  assign bus.wall_hit  = wall_q;

endmodule

// File: doc/snake_step_sequencer.md
Name: snake_step_sequencer

Overview:
- Moves the snake head one grid cell per game tick.
- Sequences a single shared 5-bit add/subtract datapath, A + ~B + 1 for decrements and A + B for increments.
- Time-multiplexes that datapath between the X and Y axes, applying wrap-around or wall detection at the grid boundaries.
- Sits between the tick generator / input decoder and the body-buffer and render logic, which consume HEAD_X/HEAD_Y on STEP_DONE.

Parameters:
- GRID_W, 32: grid width in cells, range 2..32.
- GRID_H, 32: grid height in cells, range 2..32.
- START_X, 16: head X after reset, must be < GRID_W.
- START_Y, 16: head Y after reset, must be < GRID_H.
- WRAP, 1: 1 = wrap at edges; 0 = edge crossing raises WALL_HIT.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- TICK  in  1  one-cycle request to advance one step.
- PAUSE  in  1  when high, TICK is not accepted.
- DIR_IN  in  2  requested direction: 00 up (Y-1), 01 down (Y+1), 10 left (X-1), 11 right (X+1).
- DIR_VALID  in  1  DIR_IN is sampled this cycle.
- HEAD_X  out  5  current head X.
- HEAD_Y  out  5  current head Y.
- DIR  out  2  direction committed for the current/last step.
- BUSY  out  1  step in progress.
- STEP_DONE  out  1  one-cycle pulse; HEAD_X/HEAD_Y are new this cycle.
- WALL_HIT  out  1  sticky wall collision flag; only set when WRAP=0.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high and dominates all other inputs.
- Reset values: HEAD_X=START_X, HEAD_Y=START_Y, DIR=11, pending_dir=11, BUSY=0, STEP_DONE=0, WALL_HIT=0, state=IDLE.
- RST asserted mid-step aborts the step; no STEP_DONE is produced.
- Direction capture: DIR_VALID is sampled in every state.
  - DIR_IN is written to pending_dir unless it is the reverse of the committed DIR (up<->down, left<->right); a reversal is dropped.
  - A later valid request overwrites an earlier one.
  - A request arriving while BUSY affects the next step only.
- States: IDLE -> LATCH -> CALC -> COMMIT -> IDLE.
- IDLE:
  - TICK=1, PAUSE=0 and WALL_HIT=0 -> LATCH; BUSY goes 1 next cycle.
  - Any other combination stays in IDLE.
- LATCH:
  - DIR <= pending_dir.
  - Select the axis operand (X for 1x, Y for 0x) and the op: add for 01/11, subtract for 00/10.
- CALC: the shared unit computes coord±1 mod 32 and the result is registered. Boundary flag:
  - Decrement at coord==0.
  - Increment at coord==GRID_x-1, where GRID_x is GRID_W or GRID_H per axis.
- COMMIT, boundary flag clear: write the result to the selected axis; the other axis is unchanged.
- COMMIT, boundary flag set with WRAP=1: write 0 after an increment, or GRID_x-1 after a decrement.
- COMMIT, boundary flag set with WRAP=0: HEAD unchanged; WALL_HIT <= 1.
- COMMIT, in all cases: STEP_DONE <= 1 and BUSY <= 0; next state IDLE.
- Latency: TICK accepted in cycle t -> BUSY high cycles t+1..t+3 -> STEP_DONE high and new HEAD visible in cycle t+4.
- Throughput: a TICK in cycle t+4 is accepted, giving a peak of one step per 4 cycles. A TICK arriving while BUSY is dropped, not queued.
- Reversal check uses the committed DIR, so changing the request twice within one tick interval cannot produce an immediate reversal. Example: committed right, request up then left -> left is rejected.
- PAUSE gates only step acceptance; a step already in progress completes. DIR_VALID is still captured while paused.
- WALL_HIT is sticky until RST and blocks all further steps.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, GRID 32x32, START 16,16: five TICKs 6 cycles apart, no DIR_VALID -> HEAD_X 17,18,19,20,21; HEAD_Y=16; STEP_DONE exactly 4 cycles after each TICK, BUSY high 3 cycles each.
- WRAP=1, GRID_W=20, HEAD_X=19 moving right -> TICK -> HEAD_X=0. Then request left is rejected (reversal); request up -> TICK -> HEAD_Y decrements by 1.
- WRAP=0, GRID_H=10, START_Y=0, DIR_IN=00 valid -> TICK -> STEP_DONE pulses, HEAD_Y stays 0, WALL_HIT=1; a later TICK gives no BUSY and no STEP_DONE; RST restores START values and WALL_HIT=0.
- TICK in IDLE, then TICK again 2 cycles later (while BUSY) -> exactly one STEP_DONE and one cell of movement.
- Committed right; DIR_VALID up then left in consecutive cycles -> next step moves up (Y-1). Also: PAUSE=1 with TICK -> no step; PAUSE asserted during CALC -> that step still completes.
- RST asserted in the CALC cycle -> next cycle all outputs equal their reset values and no STEP_DONE appears.
